clkdiv_ratio_ctrl: RTL and testbench
====================================

# clkdiv_ratio_ctrl

Run-time programmable clock-divider controller for the divider family. It produces a single-clock-domain divided clock (`clkout`) and a one-cycle period strobe (`tick`) from `clkin`. A new divide ratio is accepted over a valid/ready handshake and applied only at a period boundary, so no period is ever truncated or stretched. Downstream logic uses `tick` as a clock enable and `clkout` as a slow reference.

## Interface
Parameters:
- `MAX_DIV`, default 256: largest legal divide ratio.
- `DEFAULT_DIV`, default 9: ratio loaded at reset. Must satisfy 2 ≤ `DEFAULT_DIV` ≤ `MAX_DIV`.
- `WIDTH`: localparam, `$clog2(MAX_DIV+1)`. Not user-set.

Ports:
- `clkin` in 1: sole clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `enable` in 1: run request.
- `cfg_valid` in 1: new ratio offered.
- `cfg_div` in WIDTH: offered ratio.
- `cfg_ready` out 1: controller can accept a ratio.
- `cfg_err` out 1: one-cycle pulse when an offered ratio is rejected.
- `div_active` out WIDTH: ratio currently in force.
- `tick` out 1: high for 1 cycle per period.
- `clkout` out 1: divided clock.

## Operation
- **States:**
  - IDLE: counter held at 0, `clkout`=0, `tick`=0.
  - RUN: dividing, no change queued.
  - PEND: dividing, new ratio queued.
- **Period counter:**
  - `cnt` counts 0..N-1, where N = `div_active`.
  - The cycle in which `cnt` = N-1 is the "wrap". The counter then returns to 0.
- **Outputs** (registered; values are those visible while `cnt` holds a value):
  - `clkout`=1 for `cnt` < ceil(N/2), else 0. High for ceil(N/2) cycles, low for floor(N/2) cycles.
  - `tick`=1 exactly when `cnt`=N-1.
- **Handshake:**
  - Transfer occurs when `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = 1 in IDLE and RUN, 0 in PEND.
  - `cfg_valid` may stay high while `cfg_ready` is low. Its value is held by the requester and no transfer occurs.
- **Legality:**
  - `cfg_div` < 2 or > `MAX_DIV` is illegal. The transfer completes, `cfg_err` pulses 1 cycle later, and no state changes.
  - A legal value never asserts `cfg_err`.
- **Transitions:**
  - IDLE + legal transfer: `div_active` takes the new value on the next edge. State stays IDLE.
  - IDLE + `enable`=1: go to RUN, `cnt`=0 on the next edge. If a legal transfer happens in the same cycle, the new ratio is used from the first period.
  - RUN + legal transfer: store in `pend_div`, go to PEND.
  - PEND at wrap: `div_active` ← `pend_div`, `cnt` ← 0, go to RUN. Wrap in the acceptance cycle itself still uses the old N; the new ratio applies at the following wrap.
  - RUN or PEND with `enable`=0: finish the current period. At wrap, go to IDLE and apply any pending ratio.
  - `enable` reasserted before that wrap: the stop is cancelled, with no discontinuity.
- **Reset** (`rst`=0 at an edge, any state, including mid-period or PEND):
  - State IDLE, `cnt`=0, `div_active`=`DEFAULT_DIV`.
  - `clkout`=0, `tick`=0, `cfg_ready`=1, `cfg_err`=0.
  - Pending ratio discarded.

## Timing
- **Startup:** with `enable` sampled high at edge k (IDLE), from edge k the outputs are `cnt`=0 and `clkout`=1. First `tick` appears after edge k+N-1.
- **Steady state:** `tick` period is exactly N cycles and `clkout` period is exactly N cycles. No glitches; all outputs come straight from flops.
- **Ratio change:** periods of old and new ratio abut with no short or long period. The first new-ratio period starts the cycle after the old wrap.
- **`cfg_err`:** asserted in the cycle after the illegal transfer, for 1 cycle.
- **`cfg_ready`:** drops the cycle after a legal RUN transfer. It returns the cycle after the applying wrap.

## Test plan
- **Default ratio:** reset, then `enable`=1 with N=9 → `clkout` high 5 / low 4 cycles, `tick` every 9 cycles starting 8 cycles after the RUN edge; run 10 periods.
- **Mid-period change:** in RUN at N=9, transfer `cfg_div`=4 at `cnt`=3 → `cfg_ready`=0 until the 9-wrap. Next period is 4 cycles (high 2 / low 2) and `div_active`=4.
- **Illegal ratios:**
  - `cfg_div`=1 → `cfg_err` pulses once; N, state and `cfg_ready` unchanged.
  - `cfg_div`=0 and `cfg_div`=`MAX_DIV`+1 → same response.
- **Back-to-back offers and wrap edge case:**
  - Offer 6 then hold `cfg_valid` with 12 while in PEND → 12 is not accepted until after the wrap that applies 6. Periods run 9, 6, then 12.
  - Offer at exactly the wrap cycle → applied one full period later.
- **Stop and resume:** drop `enable` at `cnt`=2 with N=5 → the period completes, then IDLE with `clkout`=0. Reassert `enable` → clean restart at `cnt`=0.
- **Reset mid-operation:** assert `rst`=0 for 1 cycle in PEND → all outputs at reset values, `div_active`=9, pending ratio gone.

Source files
------------

// File: rtl/clkdiv_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// clkdiv_ratio_ctrl
//
// Run-time programmable clock divider controller. Divides clkin by a ratio N
// (div_active) and produces a divided clock (clkout, high ceil(N/2) cycles,
// low floor(N/2) cycles) and a one-cycle strobe (tick) on the last cycle of
// every period. A new ratio is offered over a valid/ready handshake and takes
// effect only at a period boundary, so periods are never truncated or
// stretched.
//
// Ports:
//   clkin       in   sole clock, rising edge
//   rst         in   synchronous reset, active low
//   enable      in   run request; dropping it lets the current period finish
//   cfg_valid   in   new ratio offered
//   cfg_div     in   offered ratio (legal range 2..MAX_DIV)
//   cfg_ready   out  controller can accept a ratio (low while one is queued)
//   cfg_err     out  one-cycle pulse the cycle after an illegal ratio transfer
//   div_active  out  ratio currently in force
//   tick        out  high on the last cycle of every period
//   clkout      out  divided clock
// -----------------------------------------------------------------------------
module clkdiv_ratio_ctrl #(
   parameter  int MAX_DIV     = 256,
   parameter  int DEFAULT_DIV = 9,
   localparam int WIDTH       = $clog2(MAX_DIV + 1)
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [WIDTH-1:0] div_active,
   output logic             tick,
   output logic             clkout
);

   localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
   localparam logic [WIDTH-1:0] DIV_MAX = WIDTH'(MAX_DIV);
   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // stopped, counter parked at 0
      ST_RUN  = 2'd1,   // dividing, nothing queued
      ST_PEND = 2'd2    // dividing, a new ratio waits for the next wrap
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] div_q,   div_d;
   logic [WIDTH-1:0] pend_q,  pend_d;
   logic             clkout_q, tick_q, ready_q, err_q;

   logic             xfer;
   logic             legal;
   logic             accept;
   logic             wrap;
   logic             running_d;
   logic [WIDTH:0]   half_d;
   logic             clkout_d, tick_d, ready_d, err_d;

   // ---------------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------------
   assign xfer   = cfg_valid && ready_q;
   assign legal  = (cfg_div >= DIV_MIN) && (cfg_div <= DIV_MAX);
   assign accept = xfer && legal;

   // Last cycle of the current period. Only meaningful while dividing.
   assign wrap   = (state_q != ST_IDLE) && (cnt_q == div_q - 1'b1);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first so that no path
   // through the case statement leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      pend_d  = pend_q;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            // An accepted ratio in IDLE is used directly, even by a period
            // that starts on this same edge.
            if (accept) begin
               div_d = cfg_div;
            end
            if (enable) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap && !enable) begin
               // Stopping at this boundary: a ratio offered now would be
               // applied on entry to IDLE anyway, so take it straight away.
               state_d = ST_IDLE;
               if (accept) begin
                  div_d = cfg_div;
               end
            end else if (accept) begin
               // Queued even when accepted on the wrap cycle: the period that
               // starts now still runs at the old ratio.
               pend_d  = cfg_div;
               state_d = ST_PEND;
            end
         end

         ST_PEND: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
               div_d   = pend_q;
               state_d = enable ? ST_RUN : ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode from the next-state values, so the registered outputs line
   // up with the counter value they describe and come straight from flops.
   // ---------------------------------------------------------------------------
   always_comb begin
      running_d = (state_d != ST_IDLE);
      half_d    = ({1'b0, div_d} + 1'b1) >> 1;   // ceil(N/2), one bit wider
      clkout_d  = running_d && ({1'b0, cnt_d} < half_d);
      tick_d    = running_d && (cnt_d == div_d - 1'b1);
      ready_d   = (state_d != ST_PEND);
      err_d     = xfer && !legal;
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   // NOTE: the pending-ratio register is reset too; it is a single word and a
   // known value keeps it from leaking X into div_active after reset.
   always_ff @(posedge clkin) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         div_q    <= DIV_RST;
         pend_q   <= '0;
         clkout_q <= 1'b0;
         tick_q   <= 1'b0;
         ready_q  <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         pend_q   <= pend_d;
         clkout_q <= clkout_d;
         tick_q   <= tick_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
      end
   end

   assign cfg_ready  = ready_q;
   assign cfg_err    = err_q;
   assign div_active = div_q;
   assign tick       = tick_q;
   assign clkout     = clkout_q;

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_ratio_ctrl
//
// Self-checking bench for clkdiv_ratio_ctrl. A waveform-level reference model
// (one queue entry per expected output cycle, refilled a whole period at a
// time) is compared against the DUT every cycle. A vector table covers the
// basic control paths, hand sequences cover the multi-cycle corner cases, and
// a randomized phase exercises everything against the model.
// -----------------------------------------------------------------------------
module tb_clkdiv_ratio_ctrl;

   localparam int MAX_DIV     = 256;
   localparam int DEFAULT_DIV = 9;
   localparam int W           = $clog2(MAX_DIV + 1);

   logic         clkin;
   logic         rst;
   logic         enable;
   logic         cfg_valid;
   logic [W-1:0] cfg_div;
   logic         cfg_ready;
   logic         cfg_err;
   logic [W-1:0] div_active;
   logic         tick;
   logic         clkout;

   int err_cnt = 0;
   int chk_cnt = 0;

   clkdiv_ratio_ctrl #(
      .MAX_DIV     (MAX_DIV),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clkin      (clkin),
      .rst        (rst),
      .enable     (enable),
      .cfg_valid  (cfg_valid),
      .cfg_div    (cfg_div),
      .cfg_ready  (cfg_ready),
      .cfg_err    (cfg_err),
      .div_active (div_active),
      .tick       (tick),
      .clkout     (clkout)
   );

   initial begin
      clkin = 1'b0;
      forever #5 clkin = ~clkin;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: expected waveform of the current period as a queue.
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic c;
      logic t;
   } wave_t;

   wave_t wq[$];
   bit    m_run;
   bit    m_pv;
   int    m_n;
   int    m_pend;
   bit    m_err;
   bit    m_clk;
   bit    m_tick;

   task automatic push_period(input int n);
      for (int i = 0; i < n; i++) begin
         wave_t w;
         w.c = (i < (n + 1) / 2);
         w.t = (i == n - 1);
         wq.push_back(w);
      end
   endtask

   task automatic pop_cycle();
      wave_t w;
      w      = wq.pop_front();
      m_clk  = w.c;
      m_tick = w.t;
   endtask

   // Advance the model by one clock edge using the inputs presented now.
   task automatic model_edge();
      bit acc, lgl;
      int d;
      d   = int'(cfg_div);
      acc = cfg_valid && !m_pv;
      lgl = (d >= 2) && (d <= MAX_DIV);
      if (!rst) begin
         m_run = 0; m_pv = 0; m_n = DEFAULT_DIV; m_err = 0;
         m_clk = 0; m_tick = 0;
         wq.delete();
         return;
      end
      m_err = acc && !lgl;
      if (!m_run) begin
         if (acc && lgl) m_n = d;
         if (enable) begin
            m_run = 1;
            push_period(m_n);
            pop_cycle();
         end else begin
            m_clk = 0; m_tick = 0;
         end
      end else begin
         if (wq.size() > 0) begin
            pop_cycle();
         end else begin
            // Previous cycle closed the period: apply any queued ratio.
            if (m_pv) begin
               m_n = m_pend; m_pv = 0;
            end
            if (enable) begin
               push_period(m_n);
               pop_cycle();
            end else begin
               m_run = 0; m_clk = 0; m_tick = 0;
            end
         end
         if (acc && lgl) begin
            if (m_run) begin
               m_pv = 1; m_pend = d;
            end else begin
               m_n = d;
            end
         end
      end
   endtask

   // One cycle: advance the model, take the edge, compare every output.
   task automatic step();
      model_edge();
      @(posedge clkin);
      #1;
      check("m_clkout",     32'(clkout),     32'(m_clk));
      check("m_tick",       32'(tick),       32'(m_tick));
      check("m_cfg_ready",  32'(cfg_ready),  32'(!m_pv));
      check("m_cfg_err",    32'(cfg_err),    32'(m_err));
      check("m_div_active", 32'(div_active), 32'(m_n));
   endtask

   // Step until tick is seen; n is the number of steps taken.
   task automatic wait_tick(input int limit, output int n);
      n = 0;
      forever begin
         step();
         n++;
         if (tick === 1'b1) break;
         if (n >= limit) begin
            check("tick_timeout", 32'(tick), 1);
            break;
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic         r, e, v;
      logic [W-1:0] d;
      logic         c, t, rdy, er;
      logic [W-1:0] dv;
   } vec_t;

   function automatic vec_t mk(input int r, e, v, d, c, t, rdy, er, dv);
      vec_t x;
      x.r = r[0]; x.e = e[0]; x.v = v[0]; x.d = W'(d);
      x.c = c[0]; x.t = t[0]; x.rdy = rdy[0]; x.er = er[0]; x.dv = W'(dv);
      return x;
   endfunction

   vec_t tbl[20];

   initial begin
      int n, hi, lo;
      int illegal_vals[3];

      rst = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;

      //             r e v  d    c t rdy er dv
      tbl[0]  = mk(0, 0, 0,   0, 0, 0, 1, 0, 9);  // reset
      tbl[1]  = mk(1, 0, 1,   3, 0, 0, 1, 0, 3);  // IDLE legal load
      tbl[2]  = mk(1, 0, 1,   1, 0, 0, 1, 1, 3);  // IDLE illegal
      tbl[3]  = mk(1, 1, 0,   0, 1, 0, 1, 0, 3);  // start, cnt0
      tbl[4]  = mk(1, 1, 0,   0, 1, 0, 1, 0, 3);  // cnt1
      tbl[5]  = mk(1, 1, 0,   0, 0, 1, 1, 0, 3);  // cnt2 wrap
      tbl[6]  = mk(1, 1, 0,   0, 1, 0, 1, 0, 3);  // cnt0
      tbl[7]  = mk(1, 1, 1,   2, 1, 0, 0, 0, 3);  // accept 2 -> PEND
      tbl[8]  = mk(1, 1, 1,   5, 0, 1, 0, 0, 3);  // held, not taken
      tbl[9]  = mk(1, 1, 1,   5, 1, 0, 1, 0, 2);  // wrap applies 2
      tbl[10] = mk(1, 1, 1,   5, 0, 1, 0, 0, 2);  // accept 5, N=2 wrap
      tbl[11] = mk(1, 1, 0,   0, 1, 0, 1, 0, 5);  // applies 5
      tbl[12] = mk(1, 0, 0,   0, 1, 0, 1, 0, 5);  // stop request cnt1
      tbl[13] = mk(1, 0, 0,   0, 1, 0, 1, 0, 5);  // cnt2
      tbl[14] = mk(1, 1, 0,   0, 0, 0, 1, 0, 5);  // cancel, cnt3
      tbl[15] = mk(1, 0, 0,   0, 0, 1, 1, 0, 5);  // cnt4 wrap
      tbl[16] = mk(1, 0, 0,   0, 0, 0, 1, 0, 5);  // IDLE
      tbl[17] = mk(1, 0, 1, 257, 0, 0, 1, 1, 5);  // MAX_DIV+1
      tbl[18] = mk(1, 0, 1,   0, 0, 0, 1, 1, 5);  // zero
      tbl[19] = mk(0, 0, 0,   0, 0, 0, 1, 0, 9);  // reset

      for (int i = 0; i < 20; i++) begin
         rst = tbl[i].r; enable = tbl[i].e; cfg_valid = tbl[i].v; cfg_div = tbl[i].d;
         step();
         check($sformatf("v%0d_clkout", i), 32'(clkout),     32'(tbl[i].c));
         check($sformatf("v%0d_tick", i),   32'(tick),       32'(tbl[i].t));
         check($sformatf("v%0d_ready", i),  32'(cfg_ready),  32'(tbl[i].rdy));
         check($sformatf("v%0d_err", i),    32'(cfg_err),    32'(tbl[i].er));
         check($sformatf("v%0d_div", i),    32'(div_active), 32'(tbl[i].dv));
      end
      rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;

      // --- Default ratio: 10 periods of N=9 --------------------------------
      enable = 1'b1;
      step();
      check("start_clkout", 32'(clkout), 1);
      wait_tick(50, n);
      check("first_tick_delay", n, 8);
      for (int p = 0; p < 10; p++) begin
         hi = 0; lo = 0;
         for (int i = 0; i < 9; i++) begin
            step();
            if (clkout) hi++; else lo++;
         end
         check($sformatf("p%0d_high", p), hi, 5);
         check($sformatf("p%0d_low", p),  lo, 4);
         check($sformatf("p%0d_tick", p), 32'(tick), 1);
      end

      // --- Mid-period change to 4 at cnt=3 ---------------------------------
      repeat (4) step();
      cfg_valid = 1'b1; cfg_div = W'(4);
      step();
      cfg_valid = 1'b0;
      check("mid_ready_drop", 32'(cfg_ready), 0);
      wait_tick(20, n);
      check("mid_old_finish", n, 4);
      check("mid_ready_at_wrap", 32'(cfg_ready), 0);
      hi = 0; lo = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 0) begin
            check("mid_ready_back", 32'(cfg_ready), 1);
            check("mid_div4", 32'(div_active), 4);
         end
         if (clkout) hi++; else lo++;
      end
      check("n4_high", hi, 2);
      check("n4_low", lo, 2);
      check("n4_tick", 32'(tick), 1);

      // --- Illegal ratios in RUN -------------------------------------------
      illegal_vals[0] = 1; illegal_vals[1] = 0; illegal_vals[2] = MAX_DIV + 1;
      for (int k = 0; k < 3; k++) begin
         cfg_valid = 1'b1; cfg_div = W'(illegal_vals[k]);
         step();
         cfg_valid = 1'b0;
         check($sformatf("ill%0d_err", illegal_vals[k]),   32'(cfg_err),    1);
         check($sformatf("ill%0d_div", illegal_vals[k]),   32'(div_active), 4);
         check($sformatf("ill%0d_ready", illegal_vals[k]), 32'(cfg_ready),  1);
         step();
         check($sformatf("ill%0d_err_end", illegal_vals[k]), 32'(cfg_err), 0);
      end

      // --- Back-to-back offers: periods 9, 6, 12 ---------------------------
      rst = 1'b0; step(); rst = 1'b1;
      enable = 1'b1;
      step();
      cfg_valid = 1'b1; cfg_div = W'(6);
      step();
      cfg_div = W'(12);
      wait_tick(20, n);
      check("b2b_period9_rest", n, 7);
      wait_tick(20, n);
      check("b2b_period6", n, 6);
      cfg_valid = 1'b0;
      wait_tick(30, n);
      check("b2b_period12", n, 12);

      // --- Offer on the wrap cycle: applied one period later ---------------
      cfg_valid = 1'b1; cfg_div = W'(3);
      step();
      cfg_valid = 1'b0;
      check("wrap_offer_ready", 32'(cfg_ready), 0);
      check("wrap_offer_div_old", 32'(div_active), 12);
      wait_tick(30, n);
      check("wrap_offer_old_rest", n, 11);
      wait_tick(10, n);
      check("wrap_offer_new", n, 3);

      // --- Stop at cnt=2 with N=5, then resume ------------------------------
      cfg_valid = 1'b1; cfg_div = W'(5);
      step();
      cfg_valid = 1'b0;
      wait_tick(10, n);
      check("stop_prep_n3", n, 2);
      repeat (3) step();
      enable = 1'b0;
      wait_tick(10, n);
      check("stop_finish", n, 2);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stop_idle%0d_clk", i),  32'(clkout), 0);
         check($sformatf("stop_idle%0d_tick", i), 32'(tick),   0);
      end
      enable = 1'b1;
      step();
      check("resume_clkout", 32'(clkout), 1);
      check("resume_div", 32'(div_active), 5);
      wait_tick(10, n);
      check("resume_first_tick", n, 4);

      // --- Reset while a ratio is pending ----------------------------------
      cfg_valid = 1'b1; cfg_div = W'(7);
      step();
      cfg_valid = 1'b0;
      check("rpend_ready", 32'(cfg_ready), 0);
      rst = 1'b0;
      step();
      check("rst_div",    32'(div_active), 9);
      check("rst_ready",  32'(cfg_ready),  1);
      check("rst_clkout", 32'(clkout),     0);
      check("rst_tick",   32'(tick),       0);
      check("rst_err",    32'(cfg_err),    0);
      rst = 1'b1;
      step();
      wait_tick(20, n);
      check("rst_pending_gone", n, 8);
      check("rst_div_after", 32'(div_active), 9);

      // --- Randomized phase against the model ------------------------------
      for (int c = 0; c < 4000; c++) begin
         int r;
         rst = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 99) < 3) enable = ~enable;
         cfg_valid = ($urandom_range(0, 99) < 25);
         r = int'($urandom_range(0, 99));
         if (r < 70)      cfg_div = W'($urandom_range(2, 12));
         else if (r < 90) begin
            case ($urandom_range(0, 3))
               0:       cfg_div = W'(0);
               1:       cfg_div = W'(1);
               2:       cfg_div = W'(MAX_DIV + 1);
               default: cfg_div = W'(511);
            endcase
         end
         else if (r < 97) cfg_div = W'($urandom_range(13, 40));
         else             cfg_div = W'(MAX_DIV);
         step();
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
